fft_bin_writer: RTL and testbench
=================================

Name: fft_bin_writer

Overview:
- Output-side writer for the spectrum RAM (O_RAM). The main state machine reads O_RAM one bin per cycle to produce Magnitude.
- Accepts complex FFT results (real, imag) on a valid/ready stream, one frame of N bins at a time.
- Computes re²+im² and writes one 32-bit word per bin at addresses 0..N-1.
- Pulses frame_done when the frame is committed, so the reader state can start.

Parameters:
- DW, 16, signed width of in_re and in_im.
- N, 64, bins per frame (power of two, 2..1024).
- AW, 6, RAM address width; must equal log2(N).

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  1-cycle request to begin a frame; honoured only in IDLE.
- in_valid  input  1  FFT result valid.
- in_ready  output  1  writer accepts a result this cycle.
- in_re  input  DW  signed real part.
- in_im  input  DW  signed imaginary part.
- ram_we  output  1  O_RAM write enable.
- ram_addr  output  AW  O_RAM write address (bin index).
- ram_din  output  32  O_RAM write data (magnitude squared).
- busy  output  1  high in any state other than IDLE.
- frame_done  output  1  1-cycle pulse after the last write of a frame.

Behaviour:
- Reset values: state IDLE; in_ready, ram_we, ram_addr, ram_din, busy, frame_done all 0; bin counter 0; pipeline valid flags 0.
- States:
  - IDLE: in_ready=0. start=1 → RUN next cycle, accept counter cleared.
  - RUN: in_ready=1 while accepted<N. A transfer is in_valid & in_ready. At accept N-1, in_ready drops combinationally on the following cycle → DRAIN.
  - DRAIN: in_ready=0. Wait until both pipeline stages are empty → DONE.
  - DONE: frame_done=1 for exactly one cycle → IDLE.
- Pipeline, 2 stages, fixed latency:
  - Transfer at cycle t: stage 1 registers the signed squares re*re and im*im (2*DW bits each, non-negative).
  - Cycle t+1: stage 2 registers the sum (2*DW+1 bits).
  - Cycle t+2: ram_we=1, ram_addr = bin index of that sample, ram_din = sum saturated to 32'hFFFFFFFF if it exceeds 32 bits. Otherwise it is zero-extended or truncated to 32 bits; with DW=16 saturation cannot occur. Maximum is (-32768)²×2 = 32'h80000000.
- Bin index:
  - Assigned in acceptance order 0..N-1, carried through the pipeline alongside the data.
  - Addresses never wrap inside a frame; exactly N writes per frame.
- Bubbles: in_valid low in RUN inserts a gap. No write occurs for that slot and the index does not advance.
- ram_we is 0 whenever no stage-2 valid is present. ram_addr and ram_din hold their last values when idle.
- start while busy is ignored, including in the DONE cycle.
- rst mid-frame: immediate return to reset values next edge; in-flight samples are discarded, no write, no frame_done.
- Back-to-back frames: start asserted in the cycle after frame_done → RUN. Minimum frame period is N+4 cycles.

Optional Feature:
- Macro FFT_BIN_WRITER_PEAK_TRACK_EN.
- Defined:
  - Adds outputs peak_bin[AW] and peak_mag[32], reset to 0.
  - Cleared on entering RUN; updated at each stage-2 write when ram_din > peak_mag (strictly greater, so ties keep the lower bin).
  - Values are stable from the frame_done pulse until the next RUN entry.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package fft_pkg:
  - state encoding typedef (IDLE, RUN, DRAIN, DONE);
  - constant MAG_W=32;
  - saturation helper function.
- Sub-module mag_sq_pipe: the 2-stage square/sum/saturate datapath with valid and index sideband.
- The top holds the FSM, counters and the optional peak tracker.

Test Plan:
- Single frame, in_valid held high, in_re=k, in_im=0 for k=0..63 → 64 writes, addr k with data k², first write 2 cycles after the first transfer, frame_done at the cycle after the last write.
- Extremes: re=-32768, im=-32768 → ram_din=32'h80000000; re=32767, im=-1 → 32'h3FFF0002.
- Random in_valid gaps (~50% duty) → still exactly 64 writes, addresses contiguous 0..63, in_ready low after the 64th accept.
- rst asserted at accept 20 → no further ram_we, no frame_done, all outputs 0 next cycle; a new start then produces a clean full frame from addr 0.
- start pulsed during RUN and during DONE → ignored, no second frame; start right after frame_done → second frame completes with identical data.
- With FFT_BIN_WRITER_PEAK_TRACK_EN: bins 5 and 40 both set to re=1000, others smaller → peak_bin=5, peak_mag=1000000 at frame_done.

Source files
------------

// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the spectrum RAM (O_RAM) writer:
//   - state_e : writer FSM encoding (IDLE, RUN, DRAIN, DONE)
//   - MAG_W   : width of one O_RAM word (magnitude squared)
//   - sat_mag : clamps a zero-extended sum to MAG_W bits
// -----------------------------------------------------------------------------
package fft_pkg;

   localparam int unsigned MAG_W = 32;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDrain,
      StDone
   } state_e;

   // Sums wider than MAG_W saturate to all-ones. Callers zero-extend into 64 bits.
   function automatic logic [MAG_W-1:0] sat_mag(input logic [63:0] sum);
      return (sum[63:MAG_W] != '0) ? {MAG_W{1'b1}} : sum[MAG_W-1:0];
   endfunction

endpackage

// File: rtl/mag_sq_pipe.sv
// -----------------------------------------------------------------------------
// mag_sq_pipe
// Two-stage re^2 + im^2 datapath with valid and bin-index sideband.
//   stage 1 : registers the signed squares re*re and im*im (2*DW bits each)
//   stage 2 : registers their sum (2*DW+1 bits); output is the saturated sum
// Data and index registers only load when their stage is valid, so the outputs
// hold their last values between samples.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid          sample enters stage 1 this cycle
//   in_re, in_im      signed real / imaginary parts (DW bits)
//   in_idx            bin index carried alongside the sample
//   s1_valid          stage 1 holds a sample
//   out_valid         stage 2 holds a sample (write strobe)
//   out_idx, out_mag  bin index and saturated magnitude squared of stage 2
// Supports DW up to 31 (sum must fit in 64 bits before saturation).
// -----------------------------------------------------------------------------
module mag_sq_pipe
   import fft_pkg::*;
#(
   parameter int unsigned DW = 16,
   parameter int unsigned AW = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [DW-1:0]    in_re,
   input  logic [DW-1:0]    in_im,
   input  logic [AW-1:0]    in_idx,
   output logic             s1_valid,
   output logic             out_valid,
   output logic [AW-1:0]    out_idx,
   output logic [MAG_W-1:0] out_mag
);

   localparam int unsigned SqW  = 2 * DW;
   localparam int unsigned SumW = SqW + 1;

   logic signed [SqW-1:0] re_ext;
   logic signed [SqW-1:0] im_ext;

   logic            v1_d, v1_q;
   logic [AW-1:0]   idx1_d, idx1_q;
   logic [SqW-1:0]  sq_re_d, sq_re_q;
   logic [SqW-1:0]  sq_im_d, sq_im_q;

   logic            v2_d, v2_q;
   logic [AW-1:0]   idx2_d, idx2_q;
   logic [SumW-1:0] sum_d, sum_q;

   assign re_ext = {{DW{in_re[DW-1]}}, in_re};
   assign im_ext = {{DW{in_im[DW-1]}}, in_im};

   always_comb begin
      v1_d    = in_valid;
      idx1_d  = idx1_q;
      sq_re_d = sq_re_q;
      sq_im_d = sq_im_q;
      v2_d    = v1_q;
      idx2_d  = idx2_q;
      sum_d   = sum_q;

      if (in_valid) begin
         // A square is never negative, so the product fits 2*DW bits unsigned.
         sq_re_d = re_ext * re_ext;
         sq_im_d = im_ext * im_ext;
         idx1_d  = in_idx;
      end

      if (v1_q) begin
         sum_d  = {1'b0, sq_re_q} + {1'b0, sq_im_q};
         idx2_d = idx1_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q    <= 1'b0;
         idx1_q  <= '0;
         sq_re_q <= '0;
         sq_im_q <= '0;
         v2_q    <= 1'b0;
         idx2_q  <= '0;
         sum_q   <= '0;
      end else begin
         v1_q    <= v1_d;
         idx1_q  <= idx1_d;
         sq_re_q <= sq_re_d;
         sq_im_q <= sq_im_d;
         v2_q    <= v2_d;
         idx2_q  <= idx2_d;
         sum_q   <= sum_d;
      end
   end

   assign s1_valid  = v1_q;
   assign out_valid = v2_q;
   assign out_idx   = idx2_q;
   assign out_mag   = sat_mag(64'(sum_q));

endmodule

// File: rtl/fft_bin_writer.sv
// -----------------------------------------------------------------------------
// fft_bin_writer
// Writes one frame of N complex FFT results into the spectrum RAM (O_RAM) as
// re^2 + im^2, one 32-bit word per bin at addresses 0..N-1, then pulses
// frame_done so the reader can start.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           request a frame (honoured only when idle)
//   in_valid/ready  input stream handshake; in_re / in_im signed DW bits
//   ram_we          O_RAM write enable
//   ram_addr        O_RAM write address (bin index)
//   ram_din         O_RAM write data (saturated magnitude squared)
//   busy            writer is not idle
//   frame_done      one-cycle pulse after the last write of a frame
// Optional feature (macro FFT_BIN_WRITER_PEAK_TRACK_EN):
//   peak_bin, peak_mag  lowest bin holding the largest magnitude of the frame
// Parameters: AW must equal log2(N); N is a power of two in 2..1024.
// -----------------------------------------------------------------------------
module fft_bin_writer
   import fft_pkg::*;
#(
   parameter int unsigned DW = 16,
   parameter int unsigned N  = 64,
   parameter int unsigned AW = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DW-1:0]    in_re,
   input  logic [DW-1:0]    in_im,
   output logic             ram_we,
   output logic [AW-1:0]    ram_addr,
   output logic [MAG_W-1:0] ram_din,
   output logic             busy,
`ifdef FFT_BIN_WRITER_PEAK_TRACK_EN
   output logic [AW-1:0]    peak_bin,
   output logic [MAG_W-1:0] peak_mag,
`endif
   output logic             frame_done
);

   localparam logic [AW-1:0] LastIdx = AW'(N - 1);

   state_e        state_d, state_q;
   logic [AW-1:0] cnt_d, cnt_q;
   logic          xfer;
   logic          s1_valid;

   // Leaving RUN on the last accept keeps in_ready low once N samples are in.
   assign in_ready = (state_q == StRun);
   assign xfer     = in_valid & in_ready;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StRun;
               cnt_d   = '0;
            end
         end
         StRun: begin
            if (xfer) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LastIdx) begin
                  state_d = StDrain;
               end
            end
         end
         StDrain: begin
            // Once stage 1 is empty, stage 2 performs the last write this cycle
            // and is empty after this edge, so frame_done follows that write.
            if (!s1_valid) begin
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy       = (state_q != StIdle);
   assign frame_done = (state_q == StDone);

   mag_sq_pipe #(
      .DW (DW),
      .AW (AW)
   ) u_pipe (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (xfer),
      .in_re     (in_re),
      .in_im     (in_im),
      .in_idx    (cnt_q),
      .s1_valid  (s1_valid),
      .out_valid (ram_we),
      .out_idx   (ram_addr),
      .out_mag   (ram_din)
   );

`ifdef FFT_BIN_WRITER_PEAK_TRACK_EN
   logic [AW-1:0]    peak_bin_d, peak_bin_q;
   logic [MAG_W-1:0] peak_mag_d, peak_mag_q;

   always_comb begin
      peak_bin_d = peak_bin_q;
      peak_mag_d = peak_mag_q;
      if (state_q == StIdle && start) begin
         peak_bin_d = '0;
         peak_mag_d = '0;
      end else if (ram_we && (ram_din > peak_mag_q)) begin
         // Strictly greater: on a tie the earlier (lower) bin is kept.
         peak_bin_d = ram_addr;
         peak_mag_d = ram_din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         peak_bin_q <= '0;
         peak_mag_q <= '0;
      end else begin
         peak_bin_q <= peak_bin_d;
         peak_mag_q <= peak_mag_d;
      end
   end

   assign peak_bin = peak_bin_q;
   assign peak_mag = peak_mag_q;
`endif

endmodule

// File: tb/tb_fft_bin_writer.sv
// -----------------------------------------------------------------------------
// tb_fft_bin_writer
// Directed bench for fft_bin_writer: ramp frame, extreme values, random input
// gaps, reset mid-frame, ignored start requests, back-to-back frames and (with
// FFT_BIN_WRITER_PEAK_TRACK_EN) the peak tracker.
// -----------------------------------------------------------------------------
module tb_fft_bin_writer;

   localparam int unsigned DW = 16;
   localparam int unsigned N  = 64;
   localparam int unsigned AW = 6;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 start = 1'b0;
   logic                 in_valid = 1'b0;
   logic signed [DW-1:0] in_re = '0;
   logic signed [DW-1:0] in_im = '0;
   logic                 in_ready;
   logic                 ram_we;
   logic [AW-1:0]        ram_addr;
   logic [31:0]          ram_din;
   logic                 busy;
   logic                 frame_done;
`ifdef FFT_BIN_WRITER_PEAK_TRACK_EN
   logic [AW-1:0]        peak_bin;
   logic [31:0]          peak_mag;
`endif

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int done_cnt = 0;
   int done_cyc = -1;
   int first_xfer_cyc = -1;
   int last_start_cyc = -1;

   int          wr_addr[$];
   logic [31:0] wr_data[$];
   int          wr_cyc[$];

   int          vec_re[N];
   int          vec_im[N];
   logic [31:0] ramp_data[N];

   fft_bin_writer #(
      .DW (DW),
      .N  (N),
      .AW (AW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_re      (in_re),
      .in_im      (in_im),
      .ram_we     (ram_we),
      .ram_addr   (ram_addr),
      .ram_din    (ram_din),
      .busy       (busy),
`ifdef FFT_BIN_WRITER_PEAK_TRACK_EN
      .peak_bin   (peak_bin),
      .peak_mag   (peak_mag),
`endif
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Write / frame_done log, sampled mid-cycle.
   always @(negedge clk) begin
      if (ram_we) begin
         wr_addr.push_back(int'(ram_addr));
         wr_data.push_back(ram_din);
         wr_cyc.push_back(cyc);
      end
      if (frame_done) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: sim time exceeded, got no end required finish");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mag(input int re, input int im);
      longint s;
      s = longint'(re) * longint'(re) + longint'(im) * longint'(im);
      return (s > longint'(32'hFFFFFFFF)) ? 32'hFFFFFFFF : s[31:0];
   endfunction

   function automatic logic [31:0] wr_d(input int i);
      return (i < wr_data.size()) ? wr_data[i] : 32'hDEADBEEF;
   endfunction

   function automatic int wr_c(input int i);
      return (i < wr_cyc.size()) ? wr_cyc[i] : -1;
   endfunction

   task automatic start_frame();
      @(posedge clk); #1;
      start = 1'b1;
      last_start_cyc = cyc;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Offers vec_*[k] until stop_at samples are accepted; start is raised
   // while k == start_at (use -1 for never).
   task automatic feed(input bit gaps, input int stop_at, input int start_at);
      int k = 0;
      int guard = 0;
      bit acc;
      first_xfer_cyc = -1;
      while (k < stop_at && guard < 1000) begin
         in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         in_re    = DW'(vec_re[k]);
         in_im    = DW'(vec_im[k]);
         start    = (k == start_at);
         @(negedge clk);
         acc = in_valid && in_ready;
         if (acc && first_xfer_cyc < 0) first_xfer_cyc = cyc;
         @(posedge clk); #1;
         if (acc) k++;
         guard++;
      end
      in_valid = 1'b0;
      start    = 1'b0;
      check_eq("feed_timeout", longint'(guard < 1000), 1);
   endtask

   task automatic wait_done(input int prev);
      int g = 0;
      while (done_cnt == prev && g < 100) begin
         @(negedge clk); #1;
         g++;
      end
      check_eq("frame_done_seen", done_cnt, prev + 1);
   endtask

   task automatic verify_frame(input string t, input int base);
      int bad_a = 0;
      int bad_d = 0;
      check_eq({t, "_nwrites"}, wr_addr.size() - base, N);
      for (int i = 0; i < N && base + i < wr_addr.size(); i++) begin
         if (wr_addr[base + i] != i) bad_a++;
         if (wr_data[base + i] !== mag(vec_re[i], vec_im[i])) bad_d++;
      end
      check_eq({t, "_addr_seq_bad"}, bad_a, 0);
      check_eq({t, "_data_bad"}, bad_d, 0);
      check_eq({t, "_done_after_last_wr"}, done_cyc,
               (wr_cyc.size() > 0) ? wr_cyc[$] + 1 : -1);
   endtask

   task automatic set_ramp();
      for (int k = 0; k < N; k++) begin
         vec_re[k] = k;
         vec_im[k] = 0;
      end
   endtask

   initial begin
      int base;
      int prev;
      int s_a;
      int diff;

      // Reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_in_ready", in_ready, 0);
      check_eq("rst_ram_we", ram_we, 0);
      check_eq("rst_ram_addr", ram_addr, 0);
      check_eq("rst_ram_din", ram_din, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_frame_done", frame_done, 0);
`ifdef FFT_BIN_WRITER_PEAK_TRACK_EN
      check_eq("rst_peak_bin", peak_bin, 0);
      check_eq("rst_peak_mag", peak_mag, 0);
`endif
      rst = 1'b0;

      // Ramp frame: re = k, im = 0 -> data k^2 at addr k
      set_ramp();
      base = wr_addr.size();
      prev = done_cnt;
      start_frame();
      check_eq("run_busy", busy, 1);
      feed(1'b0, N, -1);
      @(negedge clk);
      check_eq("ramp_ready_low_after_last", in_ready, 0);
      wait_done(prev);
      verify_frame("ramp", base);
      check_eq("ramp_first_wr_latency", wr_c(base) - first_xfer_cyc, 2);
      check_eq("ramp_data10", wr_d(base + 10), 32'd100);
      check_eq("ramp_data63", wr_d(base + 63), 32'd3969);
      for (int i = 0; i < N; i++) ramp_data[i] = wr_d(base + i);
      @(negedge clk);
      check_eq("idle_busy_after_done", busy, 0);

      // Extremes
      set_ramp();
      vec_re[0] = -32768; vec_im[0] = -32768;
      vec_re[1] = 32767;  vec_im[1] = -1;
      base = wr_addr.size();
      prev = done_cnt;
      start_frame();
      feed(1'b0, N, -1);
      wait_done(prev);
      verify_frame("ext", base);
      check_eq("ext_min_min", wr_d(base), 32'h80000000);
      check_eq("ext_max_m1", wr_d(base + 1), 32'h3FFF0002);

      // Random in_valid gaps
      for (int k = 0; k < N; k++) begin
         vec_re[k] = 3 * k - 90;
         vec_im[k] = k - 32;
      end
      base = wr_addr.size();
      prev = done_cnt;
      start_frame();
      feed(1'b1, N, -1);
      @(negedge clk);
      check_eq("gap_ready_low_after_last", in_ready, 0);
      wait_done(prev);
      verify_frame("gap", base);

      // Reset at accept 20
      set_ramp();
      prev = done_cnt;
      start_frame();
      feed(1'b0, 20, -1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      base = wr_addr.size();
      @(negedge clk);
      check_eq("mid_rst_ram_we", ram_we, 0);
      check_eq("mid_rst_ram_addr", ram_addr, 0);
      check_eq("mid_rst_ram_din", ram_din, 0);
      check_eq("mid_rst_busy", busy, 0);
      check_eq("mid_rst_in_ready", in_ready, 0);
      repeat (8) @(negedge clk);
      #1;
      check_eq("mid_rst_no_writes", wr_addr.size() - base, 0);
      check_eq("mid_rst_no_done", done_cnt, prev);
      base = wr_addr.size();
      prev = done_cnt;
      start_frame();
      feed(1'b0, N, -1);
      wait_done(prev);
      verify_frame("post_rst", base);

      // start during RUN (at k = 30) and during DONE is ignored
      base = wr_addr.size();
      prev = done_cnt;
      start_frame();
      feed(1'b0, N, 30);
      wait_done(prev);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check_eq("start_in_done_ignored", busy, 0);
      repeat (6) @(negedge clk);
      #1;
      check_eq("ign_done_count", done_cnt, prev + 1);
      verify_frame("ign", base);

      // Back-to-back frames: start in the cycle after frame_done
      base = wr_addr.size();
      prev = done_cnt;
      start_frame();
      s_a = last_start_cyc;
      feed(1'b0, N, -1);
      wait_done(prev);
      verify_frame("b2b1", base);
      start_frame();
      check_eq("b2b_period", last_start_cyc - s_a, N + 4);
      feed(1'b0, N, -1);
      wait_done(prev + 1);
      verify_frame("b2b2", base + N);
      diff = 0;
      for (int i = 0; i < N; i++) begin
         if (wr_d(base + N + i) !== ramp_data[i]) diff++;
      end
      check_eq("b2b_same_as_first_ramp", diff, 0);

`ifdef FFT_BIN_WRITER_PEAK_TRACK_EN
      // Peak tracker: ties keep the lower bin
      for (int k = 0; k < N; k++) begin
         vec_re[k] = (k % 7) * 100;
         vec_im[k] = 0;
      end
      vec_re[5]  = 1000;
      vec_re[40] = 1000;
      prev = done_cnt;
      start_frame();
      feed(1'b0, N, -1);
      wait_done(prev);
      check_eq("peak_bin", peak_bin, 5);
      check_eq("peak_mag", peak_mag, 1000000);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
